// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR: controller states,
// datapath width helpers and the output range / saturation helpers.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } fir_state_e;

  // Wide enough to hold any scaled accumulator handled by the helpers below.
  localparam int FIR_CALC_W = 64;

  // Exact accumulator width: full product plus growth for TAPS additions.
  function automatic int fir_acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // True when s does not fit in a signed out_w-bit result.
  function automatic logic fir_ovf(input logic signed [FIR_CALC_W-1:0] s, input int out_w);
    logic signed [FIR_CALC_W-1:0] hi;
    logic signed [FIR_CALC_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (s > hi) || (s < lo);
  endfunction

  // Clamp to the signed out_w-bit range when sat_en, otherwise pass through
  // so the caller's truncation gives wrap-around.
  function automatic logic signed [FIR_CALC_W-1:0] fir_limit(
    input logic signed [FIR_CALC_W-1:0] s, input int out_w, input logic sat_en);
    logic signed [FIR_CALC_W-1:0] hi;
    logic signed [FIR_CALC_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sat_en && (s > hi)) return hi;
    if (sat_en && (s < lo)) return lo;
    return s;
  endfunction

endpackage

// File: rtl/fir_mac_datapath.sv
// Multiply-accumulate datapath: product register, exact accumulator and
// output scaling. Build option FIR_SAT_EN selects clamping instead of
// wrap-around on the scaled result; ovf is the same in both builds.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 64,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr_i,
  input  logic                     prod_en_i,
  input  logic                     acc_en_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [COEF_W-1:0] c_i,
  output logic signed [OUT_W-1:0]  res_o,
  output logic                     ovf_o
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = fir_acc_w(DATA_W, COEF_W, TAPS);
`ifdef FIR_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic signed [PROD_W-1:0]     prod_q, prod_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic signed [ACC_W-1:0]      scaled;
  logic signed [FIR_CALC_W-1:0] scaled_ext;

  // Next product / accumulator; the accumulator always adds the product
  // registered one cycle earlier.
  always_comb begin
    prod_d = prod_q;
    acc_d  = acc_q;
    if (clr_i) begin
      prod_d = '0;
      acc_d  = '0;
    end else begin
      if (prod_en_i) prod_d = PROD_W'(x_i) * PROD_W'(c_i);
      if (acc_en_i)  acc_d  = acc_q + ACC_W'(prod_q);
    end
  end

  // Product and accumulator registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  assign scaled     = acc_q >>> SHIFT;
  assign scaled_ext = FIR_CALC_W'(scaled);
  assign res_o      = OUT_W'(fir_limit(scaled_ext, OUT_W, SAT_EN));
  assign ovf_o      = fir_ovf(scaled_ext, OUT_W);

endmodule

// File: rtl/fir_mac_param.sv
// Parametrised time-multiplexed FIR: controller, circular delay line and
// coefficient memory around a single MAC datapath (fir_mac).
// Build option FIR_SAT_EN (see fir_mac) clamps dout on overflow.
module fir_mac_param
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 64,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       valid_in,
  output logic                       ready_in,
  input  logic signed [DATA_W-1:0]   data_in,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_din,
  output logic                       valid_out,
  output logic signed [OUT_W-1:0]    dout,
  output logic                       ovf
);

  localparam int AW = $clog2(TAPS);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  fir_state_e state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rd_idx;
  logic signed [DATA_W-1:0] dline_q [TAPS];
  logic signed [COEF_W-1:0] coef_q  [TAPS];
  logic                     valid_q;
  logic signed [OUT_W-1:0]  dout_q;
  logic                     ovf_q;
  logic accept, coef_wr, mac_clr, prod_en, acc_en, out_load;
  logic signed [OUT_W-1:0]  res;
  logic                     res_ovf;

  // Controller: OUT also accepts so a new sample can start on the edge
  // that raises valid_out, giving one sample every TAPS+2 cycles.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    wp_d     = wp_q;
    ready_in = 1'b0;
    accept   = 1'b0;
    coef_wr  = 1'b0;
    mac_clr  = 1'b0;
    prod_en  = 1'b0;
    acc_en   = 1'b0;
    out_load = 1'b0;
    case (state_q)
      IDLE: begin
        ready_in = 1'b1;
        coef_wr  = coef_we;
        accept   = valid_in;
      end
      MAC: begin
        prod_en = 1'b1;
        acc_en  = 1'b1;
        k_d     = k_q + AW'(1);
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        acc_en  = 1'b1;
        wp_d    = (wp_q == LAST) ? '0 : wp_q + AW'(1);
        state_d = OUT;
      end
      OUT: begin
        ready_in = 1'b1;
        out_load = 1'b1;
        accept   = valid_in;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      mac_clr = 1'b1;
      k_d     = '0;
      state_d = MAC;
    end
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      k_q     <= '0;
      wp_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wp_q    <= wp_d;
    end
  end

  // Delay line and coefficient memory; the sample lands at wp on accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TAPS; i++) begin
        dline_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else begin
      if (accept)  dline_q[wp_q]    <= data_in;
      if (coef_wr) coef_q[coef_addr] <= coef_din;
    end
  end

  // x[n-k] lives at (wp-k) mod TAPS; the wrap branch handles non-power-of-2 TAPS.
  assign rd_idx = (wp_q >= k_q) ? (wp_q - k_q) : (wp_q + AW'(TAPS) - k_q);

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) u_mac (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     (mac_clr),
    .prod_en_i (prod_en),
    .acc_en_i  (acc_en),
    .x_i       (dline_q[rd_idx]),
    .c_i       (coef_q[k_q]),
    .res_o     (res),
    .ovf_o     (res_ovf)
  );

  // Output registers: dout/ovf hold between strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= out_load;
      if (out_load) begin
        dout_q <= res;
        ovf_q  <= res_ovf;
      end
    end
  end

  assign valid_out = valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fir_mac_param.sv
// Directed bench for fir_mac_param: impulse instance (SHIFT=0, OUT_W=32)
// and a default-parameter instance. Expectations follow FIR_SAT_EN.
module tb_fir_mac_param;

  localparam int TAPS = 64;
  localparam int LAT  = TAPS + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // impulse instance
  logic        i_rstn, i_valid_in, i_ready, i_coef_we, i_valid_out, i_ovf;
  logic [15:0] i_data, i_coef_din;
  logic [5:0]  i_coef_addr;
  logic [31:0] i_dout;
  // default instance
  logic        d_rstn, d_valid_in, d_ready, d_coef_we, d_valid_out, d_ovf;
  logic [15:0] d_data, d_coef_din;
  logic [5:0]  d_coef_addr;
  logic [15:0] d_dout;

  fir_mac_param #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_W(32), .SHIFT(0)) u_imp (
    .clk(clk), .rstn(i_rstn), .valid_in(i_valid_in), .ready_in(i_ready),
    .data_in(i_data), .coef_we(i_coef_we), .coef_addr(i_coef_addr),
    .coef_din(i_coef_din), .valid_out(i_valid_out), .dout(i_dout), .ovf(i_ovf)
  );

  fir_mac_param u_dut (
    .clk(clk), .rstn(d_rstn), .valid_in(d_valid_in), .ready_in(d_ready),
    .data_in(d_data), .coef_we(d_coef_we), .coef_addr(d_coef_addr),
    .coef_din(d_coef_din), .valid_out(d_valid_out), .dout(d_dout), .ovf(d_ovf)
  );

  typedef struct {
    logic [15:0] x;
    logic [31:0] y;
    logic        v;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic write_coef(input bit sel, input int addr, input logic [15:0] val);
    @(negedge clk);
    if (sel) begin d_coef_we = 1'b1; d_coef_addr = 6'(addr); d_coef_din = val; end
    else     begin i_coef_we = 1'b1; i_coef_addr = 6'(addr); i_coef_din = val; end
    @(negedge clk);
    d_coef_we = 1'b0;
    i_coef_we = 1'b0;
  endtask

  // Present one sample when ready; returns #1 after the accept edge.
  task automatic accept(input bit sel, input logic [15:0] x, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (sel ? d_ready : i_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      if (sel) begin d_valid_in = 1'b1; d_data = x; end
      else     begin i_valid_in = 1'b1; i_data = x; end
      @(posedge clk); #1;
      d_valid_in = 1'b0;
      i_valid_in = 1'b0;
    end
  endtask

  // Count edges until valid_out; lat=-1 on timeout.
  task automatic wait_out(input bit sel, output int lat, output logic [31:0] dv, output logic ov);
    lat = -1;
    for (int j = 1; j <= 300; j++) begin
      @(posedge clk); #1;
      if (sel ? d_valid_out : i_valid_out) begin lat = j; break; end
    end
    dv = sel ? {16'h0, d_dout} : i_dout;
    ov = sel ? d_ovf : i_ovf;
  endtask

  task automatic run_sample(input bit sel, input logic [15:0] x,
                            output logic [31:0] dv, output logic ov, output int lat);
    bit ok;
    accept(sel, x, ok);
    if (!ok) begin lat = -2; dv = 'x; ov = 1'bx; end
    else wait_out(sel, lat, dv, ov);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t imp_tab[71];
    vec_t g_tab[2];
    logic [31:0] dv;
    logic        ov;
    int          lat;
    bit          ok;
    bit          seen;
    int          acc_edges[$];
    int          vo_edges[$];
    int          low_cnt;

    imp_tab[0] = '{x: 16'd1, y: 32'd1, v: 1'b0};
    for (int n = 1; n < 71; n++)
      imp_tab[n] = '{x: 16'd0, y: (n < 64) ? 32'(n + 1) : 32'd0, v: 1'b0};
    g_tab[0] = '{x: 16'd1000,  y: 32'h03E7, v: 1'b0};  //  999
    g_tab[1] = '{x: 16'hFC18,  y: 32'hFC18, v: 1'b0};  // -1000

    i_rstn = 1'b0; i_valid_in = 1'b0; i_data = '0; i_coef_we = 1'b0; i_coef_addr = '0; i_coef_din = '0;
    d_rstn = 1'b0; d_valid_in = 1'b0; d_data = '0; d_coef_we = 1'b0; d_coef_addr = '0; d_coef_din = '0;
    #1;
    check("rst_ready",   d_ready, 1);
    check("rst_vout",    d_valid_out, 0);
    check("rst_dout",    d_dout, 0);
    check("rst_ovf",     d_ovf, 0);
    check("rst_i_ready", i_ready, 1);
    check("rst_i_dout",  i_dout, 0);
    repeat (2) @(negedge clk);
    i_rstn = 1'b1;
    d_rstn = 1'b1;

    // impulse response, c[k]=k+1
    for (int k = 0; k < TAPS; k++) write_coef(0, k, 16'(k + 1));
    for (int n = 0; n < 71; n++) begin
      run_sample(0, imp_tab[n].x, dv, ov, lat);
      check($sformatf("imp_lat[%0d]", n), lat, LAT);
      check($sformatf("imp_dout[%0d]", n), dv, imp_tab[n].y);
      check($sformatf("imp_ovf[%0d]", n), ov, imp_tab[n].v);
    end

    // gain with c[0]=0x7FFF
    write_coef(1, 0, 16'h7FFF);
    for (int n = 0; n < 2; n++) begin
      run_sample(1, g_tab[n].x, dv, ov, lat);
      check($sformatf("gain_dout[%0d]", n), dv, g_tab[n].y);
      check($sformatf("gain_ovf[%0d]", n), ov, g_tab[n].v);
    end

    // overflow, positive then negative full scale
    for (int k = 0; k < TAPS; k++) write_coef(1, k, 16'h7FFF);
    for (int n = 0; n < TAPS; n++) run_sample(1, 16'h7FFF, dv, ov, lat);
    check("ovf_pos_flag", ov, 1);
`ifdef FIR_SAT_EN
    check("ovf_pos_dout", dv, 32'h7FFF);
`else
    check("ovf_pos_dout", dv, 32'hFF80);
`endif
    for (int n = 0; n < TAPS; n++) run_sample(1, 16'h8000, dv, ov, lat);
    check("ovf_neg_flag", ov, 1);
`ifdef FIR_SAT_EN
    check("ovf_neg_dout", dv, 32'h8000);
`else
    check("ovf_neg_dout", dv, 32'h0040);
`endif

    // handshake: valid_in held high
    @(negedge clk);
    d_data = 16'h0;
    d_valid_in = 1'b1;
    low_cnt = 0;
    for (int e = 1; e <= 4 * LAT + 10; e++) begin
      bit r;
      r = d_ready;
      if (!r && acc_edges.size() == 1) low_cnt++;
      @(posedge clk); #1;
      if (r) acc_edges.push_back(e);
      if (d_valid_out) vo_edges.push_back(e);
      @(negedge clk);
    end
    d_valid_in = 1'b0;
    check("hs_accepts", (acc_edges.size() >= 4), 1);
    for (int i = 1; i < acc_edges.size(); i++)
      check($sformatf("hs_period[%0d]", i), acc_edges[i] - acc_edges[i-1], LAT);
    check("hs_outs", (vo_edges.size() >= 3), 1);
    for (int i = 0; i < vo_edges.size() && i < acc_edges.size(); i++)
      check($sformatf("hs_lat[%0d]", i), vo_edges[i] - acc_edges[i], LAT);
    check("hs_ready_low", low_cnt, TAPS + 1);
    repeat (2 * LAT) @(posedge clk);

    // coefficient write during MAC is ignored, in IDLE it applies
    for (int k = 1; k < TAPS; k++) write_coef(1, k, 16'h0000);
    accept(1, 16'd1000, ok);
    check("cw_accept", ok, 1);
    write_coef(1, 0, 16'h0000);
    wait_out(1, lat, dv, ov);
    check("cw_mac_dout", dv, 32'h03E7);
    write_coef(1, 0, 16'h0000);
    run_sample(1, 16'd1000, dv, ov, lat);
    check("cw_idle_dout", dv, 32'h0000);

    // reset during MAC aborts the computation
    accept(0, 16'd1, ok);
    repeat (10) @(posedge clk);
    @(negedge clk);
    i_rstn = 1'b0;
    #1;
    check("mr_ready", i_ready, 1);
    check("mr_vout",  i_valid_out, 0);
    check("mr_dout",  i_dout, 0);
    check("mr_ovf",   i_ovf, 0);
    @(negedge clk);
    i_rstn = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 2 * LAT; j++) begin
      @(posedge clk); #1;
      if (i_valid_out) seen = 1'b1;
    end
    check("mr_no_vout", seen, 0);
    for (int n = 0; n < 4; n++) begin
      run_sample(0, (n == 0) ? 16'd1 : 16'd0, dv, ov, lat);
      check($sformatf("mr_lat[%0d]", n), lat, LAT);
      check($sformatf("mr_dout[%0d]", n), dv, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
